// File: rtl/fifo_sync_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_sync_ctrl
// Brief    : Single-clock FIFO with standard/FWFT read, programmable
//            almost-full/almost-empty, occupancy count and sticky error flags.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_sync_ctrl #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter bit FWFT          = 1'b0,
    parameter int AFULL_THRESH  = (2 ** ADDR_WIDTH) - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam int                  c_depth_int = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_depth     = (ADDR_WIDTH + 1)'(c_depth_int);
    localparam logic [ADDR_WIDTH:0] c_afull     = (ADDR_WIDTH + 1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] c_aempty    = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] r_mem [c_depth_int];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_level;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_afull;
    logic                  r_aempty;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [ADDR_WIDTH:0]   w_level_nxt;

    // Acceptance uses only the registered flags, so a simultaneous opposite
    // access never rescues a write at full or a read at empty.
    assign w_wr_acc = wr_en & ~r_full;
    assign w_rd_acc = rd_en & ~r_empty;

    always_comb begin
        w_level_nxt = r_level;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_level_nxt = r_level + 1'b1;
            2'b01:   w_level_nxt = r_level - 1'b1;
            default: w_level_nxt = r_level;
        endcase
    end

    // Flags are registered from the next level so they move on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_afull     <= 1'b0;
            r_aempty    <= 1'b1;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_level     <= w_level_nxt;
            r_full      <= (w_level_nxt == c_depth);
            r_empty     <= (w_level_nxt == '0);
            r_afull     <= (w_level_nxt >= c_afull);
            r_aempty    <= (w_level_nxt <= c_aempty);
            r_overflow  <= (r_overflow  & ~clr_err) | (wr_en & r_full);
            r_underflow <= (r_underflow & ~clr_err) | (rd_en & r_empty);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            assign rd_data  = r_mem[r_rd_ptr];
            assign rd_valid = ~r_empty;
        end else begin : g_std
            logic [DATA_WIDTH-1:0] r_rd_data;
            logic                  r_rd_valid;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_rd_data  <= '0;
                    r_rd_valid <= 1'b0;
                end else begin
                    r_rd_valid <= w_rd_acc;
                    if (w_rd_acc) begin
                        r_rd_data <= r_mem[r_rd_ptr];
                    end
                end
            end

            assign rd_data  = r_rd_data;
            assign rd_valid = r_rd_valid;
        end
    endgenerate

    assign full         = r_full;
    assign almost_full  = r_afull;
    assign empty        = r_empty;
    assign almost_empty = r_aempty;
    assign level        = r_level;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule
`default_nettype wire
